qcom_tx_arb: RTL and testbench
==============================

QCOM_TX_ARB -- requirements
Module: qcom_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requester ports (2..4).
REQ-002 SHALL have parameter TOUT, default 8, c_clk cycles allowed for the link to drop tx_ready_i after issue.
REQ-003 c_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 c_rst_ni  in  1  asynchronous, active-low reset.
REQ-005 req_vld_i  in  NREQ  per-requester command valid.
REQ-006 req_ready_o  out  NREQ  per-requester slot free.
REQ-007 req_header_i  in  NREQ x 4  per-requester command header.
REQ-008 req_data_i  in  NREQ x 32  per-requester command payload.
REQ-009 tx_vld_o  out  1  command strobe to the link transmitter.
REQ-010 tx_ready_i  in  1  link transmitter idle.
REQ-011 tx_header_o  out  4  header to the link.
REQ-012 tx_data_o  out  32  payload to the link.
REQ-013 sync_prio_i  in  1  when 1, requester 0 has absolute priority.
REQ-014 err_clr_i  in  1  clears sticky error flags.
REQ-015 busy_o  out  1  arbiter not in ST_IDLE.
REQ-016 grant_o  out  2  index of the current or last granted requester.
REQ-017 sent_cnt_o  out  16  commands completed; wraps at 16'hFFFF->0.
REQ-018 drop_cnt_o  out  8  illegal headers dropped; saturates at 8'hFF.
REQ-019 err_illegal_o / err_tout_o  out  1 each  sticky error flags.

Function
REQ-020 Each requester SHALL own one holding slot; req_ready_o[i]=1 iff slot i is empty.
REQ-021 A legal header is header[3:1] in {000,001,010,011,100,110}; 101 and 111 are illegal.
REQ-022 On req_vld_i[i] & req_ready_o[i] with a legal header, slot i SHALL load header and data on that edge.
REQ-023 On req_vld_i[i] & req_ready_o[i] with an illegal header, the slot SHALL stay empty, err_illegal_o SHALL set, and drop_cnt_o SHALL increment by 1.
REQ-024 The FSM SHALL have states ST_IDLE, ST_ISSUE, ST_WAIT_BUSY and ST_WAIT_DONE.
REQ-025 In ST_IDLE, when any slot is full and tx_ready_i=1, the FSM SHALL select a winner and go to ST_ISSUE; grant_o SHALL update on that edge.
REQ-026 Winner selection: if sync_prio_i=1 and slot 0 is full, winner is 0; otherwise round-robin over full slots, starting at grant_o+1 mod NREQ.
REQ-027 In ST_ISSUE, tx_vld_o SHALL be 1 for exactly one cycle, with tx_header_o/tx_data_o taken from the winning slot and held until the next issue; next state is ST_WAIT_BUSY.
REQ-028 In ST_WAIT_BUSY, tx_ready_i=0 SHALL move the FSM to ST_WAIT_DONE.
REQ-029 In ST_WAIT_BUSY, if tx_ready_i remains 1 for TOUT cycles, the FSM SHALL set err_tout_o, free the winning slot, leave sent_cnt_o unchanged, and go to ST_IDLE.
REQ-030 In ST_WAIT_DONE, tx_ready_i=1 SHALL free the winning slot, increment sent_cnt_o and return the FSM to ST_IDLE.
REQ-031 Issue-to-issue minimum spacing SHALL be 4 cycles; there is no back-to-back tx_vld_o.
REQ-032 A freed slot SHALL show req_ready_o=1 the cycle after the free edge; loading on that same edge is not allowed.
REQ-033 Requesters SHALL be able to load non-winning slots during any state.
REQ-034 If err_clr_i coincides with a new error event, the flag SHALL be set (set wins); err_clr_i SHALL NOT clear counters.
REQ-035 busy_o SHALL be combinational from state (st != ST_IDLE); all other outputs SHALL be registered.

Reset
REQ-036 Asserting c_rst_ni low at any time, including mid-transfer, SHALL empty all slots, enter ST_IDLE, and zero tx_vld_o, tx_header_o, tx_data_o, grant_o, both counters and both error flags.
REQ-037 While in reset, req_ready_o SHALL be 0; it SHALL rise to all-ones on the first clock edge after reset release.

Structure
REQ-038 Header codes, the legality function, the TX pack-size table and the state enum SHALL live in shared package qcom_pkg, also used by the link.
REQ-039 Winner selection SHALL be one sub-module, qcom_rr_arb (req mask, last grant, prio enable -> grant index and valid), with no state of its own.

Verification
REQ-040 Single command: req0 sends header 4'b0100, data 32'hA5; tx_ready_i drops 2 cycles after tx_vld_o and returns after 20 cycles -> one tx_vld_o pulse with 0100/A5, sent_cnt_o=1, req_ready_o[0]=1 afterwards.
REQ-041 Round-robin: all three slots loaded, sync_prio_i=0, grant_o=0 -> issue order 1,2,0.
REQ-042 Priority: slots 1 and 2 pending and slot 0 reloaded after each issue, sync_prio_i=1 -> requester 0 is granted each time until its slot stays empty.
REQ-043 Illegal header: req2 sends header 4'b1010 -> no issue, err_illegal_o=1, drop_cnt_o=1; err_clr_i pulse -> err_illegal_o=0, drop_cnt_o stays 1.
REQ-044 Timeout: tx_ready_i held at 1 after issue -> err_tout_o=1 exactly TOUT cycles after ST_WAIT_BUSY entry, slot freed, sent_cnt_o unchanged.
REQ-045 Reset mid-operation: c_rst_ni pulsed low during ST_WAIT_DONE -> all outputs 0, then after reset release req_ready_o=3'b111 and no tx_vld_o.

Source files
------------

// File: rtl/qcom_pkg.sv
// Shared QCOM definitions: header opcodes, legality check,
// TX pack-size table and the TX arbiter state encoding.
package qcom_pkg;

    // Opcode lives in header[3:1]; header[0] is a per-command flag.
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_WR   = 3'b001,
        OP_RD   = 3'b010,
        OP_SYNC = 3'b011,
        OP_IRQ  = 3'b100,
        OP_CFG  = 3'b110
    } qcom_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } qcom_st_e;

    function automatic logic qcom_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_NOP, OP_WR, OP_RD,
            OP_SYNC, OP_IRQ, OP_CFG: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Link words per command (header word included).
    function automatic logic [2:0] qcom_pack_words(input logic [2:0] op);
        logic [2:0] n;
        n = 3'd0;
        case (op)
            OP_WR, OP_CFG:          n = 3'd2;
            OP_NOP, OP_RD,
            OP_SYNC, OP_IRQ:        n = 3'd1;
            default:                n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qcom_rr_arb.sv
// Stateless winner select: absolute priority for requester 0
// when enabled, else round-robin starting after the last grant.
// Ports: req (full-slot mask), last (previous grant), prio
// (requester 0 priority) -> grant (index), vld (any request).
module qcom_rr_arb #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    input  logic            prio,
    output logic [1:0]      grant,
    output logic            vld
);

    logic found;
    int   idx;

    always_comb begin
        grant = last;
        vld   = |req;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                grant = 2'(idx);
                found = 1'b1;
            end
        end
        if (prio && req[0]) begin
            grant = 2'd0;
        end
    end

endmodule

// File: rtl/qcom_tx_arb.sv
// Arbitrates NREQ single-slot command requesters onto one link
// transmitter, with timeout, error flags and sent/drop counters.
// Ports: c_clk_i/c_rst_ni, per-requester req_vld_i/req_ready_o/
// req_header_i/req_data_i, link tx_vld_o/tx_ready_i/tx_header_o/
// tx_data_o, sync_prio_i, err_clr_i, status busy_o/grant_o/
// sent_cnt_o/drop_cnt_o/err_illegal_o/err_tout_o.
module qcom_tx_arb #(
    parameter int NREQ = 3,
    parameter int TOUT = 8
) (
    input  logic              c_clk_i,
    input  logic              c_rst_ni,
    input  logic [NREQ-1:0]   req_vld_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*4-1:0] req_header_i,
    input  logic [NREQ*32-1:0] req_data_i,
    output logic              tx_vld_o,
    input  logic              tx_ready_i,
    output logic [3:0]        tx_header_o,
    output logic [31:0]       tx_data_o,
    input  logic              sync_prio_i,
    input  logic              err_clr_i,
    output logic              busy_o,
    output logic [1:0]        grant_o,
    output logic [15:0]       sent_cnt_o,
    output logic [7:0]        drop_cnt_o,
    output logic              err_illegal_o,
    output logic              err_tout_o
);
    import qcom_pkg::*;

    localparam int TW = (TOUT > 1) ? $clog2(TOUT) : 1;

    qcom_st_e        st_q, st_d;
    logic [NREQ-1:0] full_q, full_d, acc, ill;
    logic [3:0]      hdr_q [NREQ];
    logic [31:0]     dat_q [NREQ];
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            arb_vld;
    logic [1:0]      arb_gnt;
    logic            issue, free, done, tout_ev;
    logic [3:0]      sel_hdr;
    logic [31:0]     sel_dat;
    logic [2:0]      ill_n;
    logic [8:0]      drop_sum;

    qcom_rr_arb #(.NREQ(NREQ)) u_arb (
        .req   (full_q),
        .last  (grant_o),
        .prio  (sync_prio_i),
        .grant (arb_gnt),
        .vld   (arb_vld)
    );

    assign busy_o = (st_q != ST_IDLE);

    always_comb begin
        st_d    = st_q;
        tcnt_d  = tcnt_q;
        issue   = 1'b0;
        free    = 1'b0;
        done    = 1'b0;
        tout_ev = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (arb_vld && tx_ready_i) begin
                    st_d  = ST_ISSUE;
                    issue = 1'b1;
                end
            end
            ST_ISSUE: begin
                st_d   = ST_WAIT_BUSY;
                tcnt_d = '0;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready_i) begin
                    st_d = ST_WAIT_DONE;
                end else if (tcnt_q == TW'(TOUT - 1)) begin
                    st_d    = ST_IDLE;
                    free    = 1'b1;
                    tout_ev = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready_i) begin
                    st_d = ST_IDLE;
                    free = 1'b1;
                    done = 1'b1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // req_ready_o is ~full one edge late, so a slot freed on an
    // edge cannot be reloaded on that same edge.
    always_comb begin
        full_d  = full_q;
        acc     = '0;
        ill     = '0;
        ill_n   = '0;
        sel_hdr = '0;
        sel_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            acc[i] = req_vld_i[i] & req_ready_o[i];
            ill[i] = acc[i] & ~qcom_legal(req_header_i[i*4+1 +: 3]);
            if (free && grant_o == 2'(i)) begin
                full_d[i] = 1'b0;
            end
            if (acc[i] && !ill[i]) begin
                full_d[i] = 1'b1;
            end
            ill_n = ill_n + 3'(ill[i]);
            if (arb_gnt == 2'(i)) begin
                sel_hdr = hdr_q[i];
                sel_dat = dat_q[i];
            end
        end
        drop_sum = {1'b0, drop_cnt_o} + 9'(ill_n);
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            st_q          <= ST_IDLE;
            tcnt_q        <= '0;
            full_q        <= '0;
            req_ready_o   <= '0;
            tx_vld_o      <= 1'b0;
            tx_header_o   <= '0;
            tx_data_o     <= '0;
            grant_o       <= '0;
            sent_cnt_o    <= '0;
            drop_cnt_o    <= '0;
            err_illegal_o <= 1'b0;
            err_tout_o    <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                hdr_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            st_q        <= st_d;
            tcnt_q      <= tcnt_d;
            full_q      <= full_d;
            req_ready_o <= ~full_d;
            tx_vld_o    <= issue;
            if (issue) begin
                grant_o     <= arb_gnt;
                tx_header_o <= sel_hdr;
                tx_data_o   <= sel_dat;
            end
            if (done) begin
                sent_cnt_o <= sent_cnt_o + 16'd1;
            end
            // Set beats clear on the same edge.
            if (|ill) begin
                err_illegal_o <= 1'b1;
                drop_cnt_o    <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end else if (err_clr_i) begin
                err_illegal_o <= 1'b0;
            end
            if (tout_ev) begin
                err_tout_o <= 1'b1;
            end else if (err_clr_i) begin
                err_tout_o <= 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && !ill[i]) begin
                    hdr_q[i] <= req_header_i[i*4 +: 4];
                    dat_q[i] <= req_data_i[i*32 +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_qcom_tx_arb.sv
// Directed self-checking bench for qcom_tx_arb.
// Drives requester and link stimulus, checks hand-computed values.
module tb_qcom_tx_arb;

    localparam int NREQ = 3;
    localparam int TOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_vld;
    logic [2:0]  req_ready;
    logic [11:0] req_hdr;
    logic [95:0] req_data;
    logic        tx_vld;
    logic        tx_ready;
    logic [3:0]  tx_hdr;
    logic [31:0] tx_data;
    logic        sync_prio;
    logic        err_clr;
    logic        busy;
    logic [1:0]  grant;
    logic [15:0] sent;
    logic [7:0]  drop;
    logic        err_ill;
    logic        err_to;

    int   tests = 0;
    int   fails = 0;
    int   vld_cnt = 0;
    int   b2b = 0;
    int   vld_mark;
    logic vld_prev = 1'b0;
    logic [1:0] g;
    logic [3:0] h;

    qcom_tx_arb #(.NREQ(NREQ), .TOUT(TOUT)) dut (
        .c_clk_i       (clk),
        .c_rst_ni      (rst_n),
        .req_vld_i     (req_vld),
        .req_ready_o   (req_ready),
        .req_header_i  (req_hdr),
        .req_data_i    (req_data),
        .tx_vld_o      (tx_vld),
        .tx_ready_i    (tx_ready),
        .tx_header_o   (tx_hdr),
        .tx_data_o     (tx_data),
        .sync_prio_i   (sync_prio),
        .err_clr_i     (err_clr),
        .busy_o        (busy),
        .grant_o       (grant),
        .sent_cnt_o    (sent),
        .drop_cnt_o    (drop),
        .err_illegal_o (err_ill),
        .err_tout_o    (err_to)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_vld === 1'b1) begin
            vld_cnt++;
            if (vld_prev === 1'b1) b2b++;
        end
        vld_prev = tx_vld;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int i, logic [3:0] hv, logic [31:0] dv);
        req_vld[i]           = 1'b1;
        req_hdr[i*4 +: 4]    = hv;
        req_data[i*32 +: 32] = dv;
    endtask

    // Link model: raise ready, wait for the strobe, go busy for
    // two cycles, complete, then park the link not-ready.
    task automatic serve(output logic [1:0] go, output logic [3:0] ho);
        tx_ready = 1'b1;
        for (int n = 0; n < 20 && tx_vld !== 1'b1; n++) step();
        check("serve_vld", 32'(tx_vld), 32'd1);
        go = grant;
        ho = tx_hdr;
        step();
        tx_ready = 1'b0;
        step();
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_vld   = '0;
        req_hdr   = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        sync_prio = 1'b0;
        err_clr   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_vld", 32'(tx_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent", 32'(sent), 32'd0);
        rst_n = 1'b1;
        check("rel_ready_pre", 32'(req_ready), 32'd0);
        step();
        check("rel_ready", 32'(req_ready), 32'h7);

        // Single command
        load(0, 4'b0100, 32'hA5);
        step();
        req_vld = '0;
        check("sc_ready0_full", 32'(req_ready[0]), 32'd0);
        check("sc_busy_idle", 32'(busy), 32'd0);
        step();
        check("sc_vld", 32'(tx_vld), 32'd1);
        check("sc_hdr", 32'(tx_hdr), 32'h4);
        check("sc_data", tx_data, 32'hA5);
        check("sc_grant", 32'(grant), 32'd0);
        check("sc_busy", 32'(busy), 32'd1);
        step();
        check("sc_vld_once", 32'(tx_vld), 32'd0);
        step();
        tx_ready = 1'b0;
        repeat (20) step();
        check("sc_wait_busy", 32'(busy), 32'd1);
        check("sc_wait_sent", 32'(sent), 32'd0);
        tx_ready = 1'b1;
        step();
        check("sc_sent", 32'(sent), 32'd1);
        check("sc_ready0_free", 32'(req_ready[0]), 32'd1);
        check("sc_idle", 32'(busy), 32'd0);

        // Round-robin 1,2,0 from last grant 0
        tx_ready = 1'b0;
        load(0, 4'b0000, 32'h10);
        load(1, 4'b0010, 32'h11);
        load(2, 4'b1100, 32'h12);
        step();
        req_vld = '0;
        check("rr_ready_full", 32'(req_ready), 32'd0);
        serve(g, h);
        check("rr_grant_a", 32'(g), 32'd1);
        check("rr_hdr_a", 32'(h), 32'h2);
        serve(g, h);
        check("rr_grant_b", 32'(g), 32'd2);
        check("rr_hdr_b", 32'(h), 32'hC);
        serve(g, h);
        check("rr_grant_c", 32'(g), 32'd0);
        check("rr_hdr_c", 32'(h), 32'h0);
        check("rr_sent", 32'(sent), 32'd4);
        check("rr_ready_free", 32'(req_ready), 32'h7);

        // Priority for requester 0
        sync_prio = 1'b1;
        load(0, 4'b0110, 32'h20);
        load(1, 4'b1000, 32'h21);
        load(2, 4'b0011, 32'h22);
        step();
        req_vld = '0;
        serve(g, h);
        check("pr_grant_a", 32'(g), 32'd0);
        load(0, 4'b0110, 32'h23);
        step();
        req_vld = '0;
        serve(g, h);
        check("pr_grant_b", 32'(g), 32'd0);
        load(0, 4'b0110, 32'h24);
        step();
        req_vld = '0;
        serve(g, h);
        check("pr_grant_c", 32'(g), 32'd0);
        serve(g, h);
        check("pr_grant_d", 32'(g), 32'd1);
        check("pr_hdr_d", 32'(h), 32'h8);
        serve(g, h);
        check("pr_grant_e", 32'(g), 32'd2);
        sync_prio = 1'b0;
        check("pr_sent", 32'(sent), 32'd9);

        // Illegal header, clear, set-wins
        tx_ready = 1'b1;
        load(2, 4'b1010, 32'hDEAD);
        step();
        req_vld = '0;
        check("ill_err", 32'(err_ill), 32'd1);
        check("ill_drop", 32'(drop), 32'd1);
        check("ill_ready2", 32'(req_ready[2]), 32'd1);
        step();
        check("ill_noissue", 32'(tx_vld), 32'd0);
        check("ill_busy", 32'(busy), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ill_clr", 32'(err_ill), 32'd0);
        check("ill_clr_drop", 32'(drop), 32'd1);
        err_clr = 1'b1;
        load(2, 4'b1110, 32'hBEEF);
        step();
        req_vld = '0;
        err_clr = 1'b0;
        check("setwin_err", 32'(err_ill), 32'd1);
        check("setwin_drop", 32'(drop), 32'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("setwin_clr", 32'(err_ill), 32'd0);

        // Timeout: link never drops ready
        tx_ready = 1'b1;
        load(1, 4'b0100, 32'h55);
        step();
        req_vld = '0;
        step();
        check("to_vld", 32'(tx_vld), 32'd1);
        check("to_grant", 32'(grant), 32'd1);
        step();
        repeat (TOUT - 1) step();
        check("to_pre_err", 32'(err_to), 32'd0);
        check("to_pre_busy", 32'(busy), 32'd1);
        step();
        check("to_err", 32'(err_to), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_ready1", 32'(req_ready[1]), 32'd1);
        check("to_sent", 32'(sent), 32'd9);

        // Reset during WAIT_DONE
        load(0, 4'b0010, 32'h66);
        load(2, 4'b0010, 32'h77);
        step();
        req_vld = '0;
        step();
        check("rm_vld", 32'(tx_vld), 32'd1);
        check("rm_grant", 32'(grant), 32'd2);
        check("rm_data", tx_data, 32'h77);
        step();
        tx_ready = 1'b0;
        step();
        step();
        check("rm_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rm_vld0", 32'(tx_vld), 32'd0);
        check("rm_hdr0", 32'(tx_hdr), 32'd0);
        check("rm_data0", tx_data, 32'd0);
        check("rm_grant0", 32'(grant), 32'd0);
        check("rm_sent0", 32'(sent), 32'd0);
        check("rm_drop0", 32'(drop), 32'd0);
        check("rm_errill0", 32'(err_ill), 32'd0);
        check("rm_errto0", 32'(err_to), 32'd0);
        check("rm_ready0", 32'(req_ready), 32'd0);
        check("rm_busy0", 32'(busy), 32'd0);
        tx_ready = 1'b1;
        step();
        rst_n = 1'b1;
        check("rm_rel_pre", 32'(req_ready), 32'd0);
        vld_mark = vld_cnt;
        step();
        check("rm_rel_ready", 32'(req_ready), 32'h7);
        repeat (5) step();
        check("rm_novld", 32'(vld_cnt - vld_mark), 32'd0);
        check("rm_idle", 32'(busy), 32'd0);

        // Whole-run strobe accounting
        check("total_issues", 32'(vld_cnt), 32'd11);
        check("no_back_to_back", 32'(b2b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
